dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (CPU) and a DMA/debug loader (DMA).
- CPU has fixed priority with zero added latency.
- DMA gets bounded bursts, plus a starvation override that stalls the CPU.
- Sits between the memory stage and DMEM; drives the DMEM we/wmask/addr/wdata port and returns read data to both requesters.

Parameters:
- BURST_MAX, 4: max consecutive DMA beats before the port returns to CPU-owned state (>=1).
- STARVE_LIMIT, 8: cycles a DMA request may be denied before it pre-empts the CPU (>=1).
- CNT_W, 4: width of the beat and wait counters; must hold max(BURST_MAX, STARVE_LIMIT).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  memory stage access (load or store) this cycle.
- cpu_we  in  1  CPU store.
- cpu_wmask  in  4  CPU byte-lane write mask.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU lane-replicated store data.
- cpu_rdata  out  32  mem_rdata, combinational.
- cpu_stall  out  1  cpu_req && !cpu_gnt; pipeline holds M stage and earlier.
- dma_req  in  1  DMA beat request, held until granted.
- dma_we  in  1  DMA write; always a full word.
- dma_addr  in  32  DMA word address (byte address, [1:0] ignored).
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  beat accepted this cycle; DMA advances addr/data next cycle.
- dma_rdata  out  32  registered read data.
- dma_rvalid  out  1  pulses the cycle after a granted DMA read.
- mem_we  out  1  DMEM write enable.
- mem_wmask  out  4  DMEM byte mask.
- mem_addr  out  32  DMEM address.
- mem_wdata  out  32  DMEM write data.
- mem_rdata  in  32  DMEM combinational read data.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=S_CPU, beat_cnt=0, wait_cnt=0, dma_rvalid=0, dma_rdata=0.
  - Combinational outputs follow from state: with no requests, mem_we=0 and all grants are 0.
- States: S_CPU (CPU-owned, default) and S_DMA (DMA burst in progress).
- Grant logic in S_CPU:
  - cpu_gnt = cpu_req && !(dma_req && wait_cnt==STARVE_LIMIT).
  - dma_gnt = dma_req && !cpu_gnt.
- Grant logic in S_DMA:
  - dma_gnt = dma_req && beat_cnt<BURST_MAX.
  - cpu_gnt = cpu_req && !dma_gnt.
- Mux:
  - Granted requester drives mem_addr, mem_wdata, mem_we, mem_wmask.
  - DMA uses mask 4'b1111 and addr {dma_addr[31:2],2'b00}.
  - No grant: mem_we=0, mem_wmask=0, mem_addr=cpu_addr.
  - mem_we is asserted only for a granted writer.
- Transitions:
  - S_CPU -> S_DMA when dma_gnt; beat_cnt<=1.
  - S_DMA with dma_gnt: beat_cnt<=beat_cnt+1, stay in S_DMA.
  - S_DMA without dma_gnt (dma_req dropped, or beat_cnt==BURST_MAX): -> S_CPU, beat_cnt<=0. The CPU is served in that same cycle if it requests.
- wait_cnt:
  - In S_CPU with dma_req && !dma_gnt: increment, saturating at STARVE_LIMIT.
  - Cleared on any dma_gnt.
  - Held otherwise.
- Latency and handshake:
  - CPU read data is valid in the same cycle as cpu_gnt (zero added latency).
  - A stalled CPU keeps cpu_req/addr/wdata stable; a stalled store must never partially write.
  - DMA read: dma_rvalid=1 and dma_rdata=mem_rdata captured on the cycle after dma_gnt && !dma_we.
- Back-to-back DMA:
  - Throughput is 1 beat/cycle inside a burst.
  - After BURST_MAX beats the port returns to S_CPU for at least one cycle, even if cpu_req=0. With cpu_req=0, DMA is re-granted in that cycle from S_CPU.
- Simultaneous first requests in S_CPU with wait_cnt<STARVE_LIMIT: CPU wins.
- Reset mid-burst: the burst is abandoned, the pending dma_rvalid is dropped, and DMA must re-request.
- Invariant: cpu_gnt && dma_gnt is never 1.

Decomposition:
- Shared package holds:
  - state enum (S_CPU, S_DMA);
  - constant WMASK_WORD=4'b1111;
  - default BURST_MAX/STARVE_LIMIT localparams.
- One natural sub-module, dmem_req_mux: purely combinational selection of addr/wdata/we/wmask by grant.
- FSM and counters stay in dmem_arbiter.

Test Plan:
- CPU only: cpu_req=1, load addr 0x10 holding 0xDEADBEEF -> cpu_rdata=0xDEADBEEF in the same cycle, cpu_stall=0; mem_we=0.
- DMA burst: dma_req held, cpu idle, BURST_MAX=4, writes 0x100..0x10C -> dma_gnt for 4 cycles. Then 1 cycle in S_CPU with dma_gnt=1 from S_CPU, and mem_wmask=1111 on every beat.
- Contention: cpu_req and dma_req rise together -> CPU granted. Then with cpu_req held continuously, DMA is granted on the 9th cycle (STARVE_LIMIT=8): cpu_stall=1 and cpu store not written.
- Burst yield: cpu_req rises during DMA beat 2 -> cpu_stall=1 for beats 2-4, CPU granted on the cycle after beat 4, and wait_cnt=0 afterwards.
- DMA read: granted read of 0x200=0x12345678 -> dma_rvalid=1, dma_rdata=0x12345678 exactly one cycle later.
- Reset mid-burst: rst=1 during beat 2 -> next cycle state=S_CPU, dma_gnt=0, dma_rvalid=0, beat_cnt=0, wait_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: state encoding,
// the DMEM command payload, and the default burst/starvation limits.
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned MASK_W           = 4;
   localparam int unsigned DEF_BURST_MAX    = 4;
   localparam int unsigned DEF_STARVE_LIMIT = 8;
   localparam int unsigned DEF_CNT_W        = 4;

   localparam logic [MASK_W-1:0] WMASK_WORD = 4'b1111;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } state_e;

   // One DMEM access as presented on the single memory port
   typedef struct packed {
      logic              we;
      logic [MASK_W-1:0] wmask;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/dmem_req_mux.sv
// Steers the granted requester's command onto the DMEM port; with no grant the
// port idles on the CPU address with writes disabled.
module dmem_req_mux
   import dmem_arbiter_pkg::*;
(
   input  logic     cpu_gnt,
   input  logic     dma_gnt,
   input  mem_cmd_t cpu_cmd,
   input  mem_cmd_t dma_cmd,
   output mem_cmd_t mem_cmd
);

   always_comb begin
      mem_cmd       = cpu_cmd;
      mem_cmd.we    = 1'b0;
      mem_cmd.wmask = '0;
      if (dma_gnt) begin
         mem_cmd = dma_cmd;
      end else if (cpu_gnt) begin
         mem_cmd = cpu_cmd;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the CPU memory stage (fixed priority,
// zero added latency) and a DMA loader with bounded bursts and starvation override.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned BURST_MAX    = DEF_BURST_MAX,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [MASK_W-1:0] cpu_wmask,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_we,
   output logic [MASK_W-1:0] mem_wmask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q;
   logic              cpu_gnt_c;
   logic              dma_gnt_c;
   logic              starved_c;

   mem_cmd_t cpu_cmd, dma_cmd, mem_cmd;

   assign starved_c = dma_req && (wait_q == CNT_W'(STARVE_LIMIT));

   // Grant selection, burst/starvation counters and next state
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      wait_d    = wait_q;
      cpu_gnt_c = 1'b0;
      dma_gnt_c = 1'b0;

      unique case (state_q)
         S_CPU: begin
            cpu_gnt_c = cpu_req && !starved_c;
            dma_gnt_c = dma_req && !cpu_gnt_c;
            if (dma_gnt_c) begin
               state_d = S_DMA;
               beat_d  = CNT_W'(1);
            end
         end
         S_DMA: begin
            dma_gnt_c = dma_req && (beat_q < CNT_W'(BURST_MAX));
            cpu_gnt_c = cpu_req && !dma_gnt_c;
            if (dma_gnt_c) begin
               beat_d = beat_q + CNT_W'(1);
            end else begin
               state_d = S_CPU;
               beat_d  = '0;
            end
         end
         default: begin
            state_d = S_CPU;
            beat_d  = '0;
         end
      endcase

      if (dma_gnt_c) begin
         wait_d = '0;
      end else if ((state_q == S_CPU) && dma_req && (wait_q < CNT_W'(STARVE_LIMIT))) begin
         wait_d = wait_q + CNT_W'(1);
      end

      rvalid_d = dma_gnt_c && !dma_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_CPU;
         beat_q   <= '0;
         wait_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         wait_q   <= wait_d;
         rvalid_q <= rvalid_d;
         if (rvalid_d) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   assign cpu_cmd.we    = cpu_we;
   assign cpu_cmd.wmask = cpu_wmask;
   assign cpu_cmd.addr  = cpu_addr;
   assign cpu_cmd.wdata = cpu_wdata;

   // DMA always moves whole aligned words
   assign dma_cmd.we    = dma_we;
   assign dma_cmd.wmask = WMASK_WORD;
   assign dma_cmd.addr  = dma_addr & ~ADDR_W'(3);
   assign dma_cmd.wdata = dma_wdata;

   dmem_req_mux u_mux (
      .cpu_gnt (cpu_gnt_c),
      .dma_gnt (dma_gnt_c),
      .cpu_cmd (cpu_cmd),
      .dma_cmd (dma_cmd),
      .mem_cmd (mem_cmd)
   );

   assign mem_we     = mem_cmd.we;
   assign mem_wmask  = mem_cmd.wmask;
   assign mem_addr   = mem_cmd.addr;
   assign mem_wdata  = mem_cmd.wdata;

   assign cpu_rdata  = mem_rdata;
   assign cpu_stall  = cpu_req && !cpu_gnt_c;
   assign dma_gnt    = dma_gnt_c;
   assign dma_rdata  = rdata_q;
   assign dma_rvalid = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected port events and
// per-cycle status; a negedge monitor pops and compares against the DUT.
module tb_dmem_arbiter;

   localparam int K_CPU = 0;
   localparam int K_DMA = 1;
   localparam int K_RV  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [3:0]  cpu_wmask;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_gnt, dma_rvalid;
   logic        mem_we;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        load_mem;
   logic        done = 1'b0;

   logic [31:0] mem [256];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  mask;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      int          cyc;
      bit          is_mem;
      logic        stall, dgnt, rv, mwe;
      int          idx;
      logic [31:0] val;
   } st_t;

   ev_t exp_q[$];
   st_t st_q[$];

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_wmask  (cpu_wmask),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .mem_we     (mem_we),
      .mem_wmask  (mem_wmask),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DMEM: combinational read, byte-masked write
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[4]   <= 32'hDEAD_BEEF;
         mem[128] <= 32'h1234_5678;
      end else if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_wmask = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
   endtask

   task automatic cpu_load(input logic [31:0] a);
      cpu_req = 1; cpu_we = 0; cpu_wmask = 4'h0; cpu_addr = a; cpu_wdata = 0;
   endtask

   task automatic cpu_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      cpu_req = 1; cpu_we = 1; cpu_wmask = m; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic dma_set(input logic we, input logic [31:0] a, input logic [31:0] d);
      dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
   endtask

   task automatic exp_ev(input int k, input logic [31:0] a, input logic we,
                         input logic [3:0] m, input logic [31:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.we = we; e.mask = m; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic exp_st(input logic stall, input logic dgnt, input logic rv, input logic mwe);
      st_t s;
      s.cyc = cyc; s.is_mem = 0; s.stall = stall; s.dgnt = dgnt; s.rv = rv; s.mwe = mwe;
      s.idx = 0; s.val = 0;
      st_q.push_back(s);
   endtask

   task automatic exp_mem(input int idx, input logic [31:0] v);
      st_t s;
      s.cyc = cyc; s.is_mem = 1; s.stall = 0; s.dgnt = 0; s.rv = 0; s.mwe = 0;
      s.idx = idx; s.val = v;
      st_q.push_back(s);
   endtask

   // Monitor: the only process that counts and judges
   task automatic chk_ev(input int k, input logic [31:0] a, input logic we,
                         input logic [3:0] m, input logic [31:0] d);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event cyc%0d: kind%0d addr=%h we=%b mask=%h data=%h, required none",
                  cyc, k, a, we, m, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr != a || e.we != we || e.mask != m || e.data != d) begin
            fails++;
            $display("FAIL event cyc%0d: kind%0d addr=%h we=%b mask=%h data=%h, required kind%0d addr=%h we=%b mask=%h data=%h",
                     cyc, k, a, we, m, d, e.kind, e.addr, e.we, e.mask, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      st_t s;
      if (done) begin
         tests++;
         if (exp_q.size() != 0 || st_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d events and %0d status entries pending, required 0",
                     exp_q.size(), st_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end else if (!rst) begin
         if (cpu_req && !cpu_stall)
            chk_ev(K_CPU, mem_addr, mem_we, mem_wmask, mem_we ? mem_wdata : cpu_rdata);
         if (dma_gnt)
            chk_ev(K_DMA, mem_addr, mem_we, mem_wmask, mem_we ? mem_wdata : mem_rdata);
         if (dma_rvalid)
            chk_ev(K_RV, 32'h0, 1'b0, 4'h0, dma_rdata);
         tests++;
         if (cpu_req && !cpu_stall && dma_gnt) begin
            fails++;
            $display("FAIL exclusive_grant cyc%0d: cpu_gnt=1 dma_gnt=1, required at most one", cyc);
         end
         while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            tests++;
            if (s.is_mem) begin
               if (mem[s.idx] !== s.val) begin
                  fails++;
                  $display("FAIL mem_word cyc%0d: mem[%0d]=%h, required %h", cyc, s.idx, mem[s.idx], s.val);
               end
            end else if (cpu_stall !== s.stall || dma_gnt !== s.dgnt ||
                         dma_rvalid !== s.rv || mem_we !== s.mwe) begin
               fails++;
               $display("FAIL status cyc%0d: stall=%b dma_gnt=%b rvalid=%b mem_we=%b, required %b %b %b %b",
                        cyc, cpu_stall, dma_gnt, dma_rvalid, mem_we, s.stall, s.dgnt, s.rv, s.mwe);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; load_mem = 1; idle();
      step(); step();
      rst = 0; load_mem = 0;

      // Reset state, no requests
      exp_st(0, 0, 0, 0);
      step();

      // CPU-only load and byte-masked store
      cpu_load(32'h10);
      exp_ev(K_CPU, 32'h10, 0, 4'h0, 32'hDEAD_BEEF);
      exp_st(0, 0, 0, 0);
      step();
      cpu_store(32'h20, 4'b0011, 32'hAABB_CCDD);
      exp_ev(K_CPU, 32'h20, 1, 4'b0011, 32'hAABB_CCDD);
      exp_st(0, 0, 0, 1);
      step();
      idle();
      exp_mem(8, 32'h0000_CCDD);
      step();

      // DMA write burst: 4 beats, one dead cycle in S_DMA, then re-grant from S_CPU
      for (int i = 0; i < 4; i++) begin
         dma_set(1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
         exp_ev(K_DMA, 32'h100 + 32'(4 * i), 1, 4'hF, 32'hB000_0000 + 32'(i));
         step();
      end
      dma_set(1, 32'h110, 32'hB000_0004);
      exp_st(0, 0, 0, 0);
      step();
      exp_ev(K_DMA, 32'h110, 1, 4'hF, 32'hB000_0004);
      step();
      idle();
      exp_st(0, 0, 0, 0);
      step();
      exp_mem(64, 32'hB000_0000);
      exp_mem(67, 32'hB000_0003);
      exp_mem(68, 32'hB000_0004);
      step();

      // Burst yield: CPU arrives on beat 2, served right after beat 4
      for (int i = 0; i < 4; i++) begin
         dma_set(1, 32'h140 + 32'(4 * i), 32'hC000_0000 + 32'(i));
         if (i >= 1) begin
            cpu_load(32'h10);
            exp_st(1, 1, 0, 1);
         end
         exp_ev(K_DMA, 32'h140 + 32'(4 * i), 1, 4'hF, 32'hC000_0000 + 32'(i));
         step();
      end
      dma_set(1, 32'h150, 32'hC000_0004);
      exp_ev(K_CPU, 32'h10, 0, 4'h0, 32'hDEAD_BEEF);
      exp_st(0, 0, 0, 0);
      step();
      cpu_req = 0;
      exp_ev(K_DMA, 32'h150, 1, 4'hF, 32'hC000_0004);
      step();
      idle();
      step();

      // Contention: CPU wins 8 cycles, DMA pre-empts on the 9th
      dma_set(1, 32'h180, 32'hCAFE_F00D);
      for (int i = 1; i <= 8; i++) begin
         cpu_load(32'h10);
         exp_ev(K_CPU, 32'h10, 0, 4'h0, 32'hDEAD_BEEF);
         if (i == 1 || i == 8) exp_st(0, 0, 0, 0);
         step();
      end
      cpu_store(32'h40, 4'hF, 32'h7777_7777);
      exp_ev(K_DMA, 32'h180, 1, 4'hF, 32'hCAFE_F00D);
      exp_st(1, 1, 0, 1);
      step();
      dma_req = 0;
      exp_mem(16, 32'h0);
      exp_ev(K_CPU, 32'h40, 1, 4'hF, 32'h7777_7777);
      step();
      idle();
      exp_mem(16, 32'h7777_7777);
      exp_mem(96, 32'hCAFE_F00D);
      step();

      // DMA read with unaligned low address bits
      dma_set(0, 32'h202, 32'h0);
      exp_ev(K_DMA, 32'h200, 0, 4'hF, 32'h1234_5678);
      step();
      idle();
      exp_ev(K_RV, 32'h0, 0, 4'h0, 32'h1234_5678);
      exp_st(0, 0, 1, 0);
      step();
      exp_st(0, 0, 0, 0);
      step();

      // Reset during beat 2 of a read burst
      dma_set(0, 32'h200, 32'h0);
      exp_ev(K_DMA, 32'h200, 0, 4'hF, 32'h1234_5678);
      step();
      dma_set(0, 32'h204, 32'h0);
      rst = 1;
      step();
      rst = 0;
      dma_req = 0;
      exp_st(0, 0, 0, 0);
      step();
      cpu_load(32'h10);
      dma_set(0, 32'h200, 32'h0);
      exp_ev(K_CPU, 32'h10, 0, 4'h0, 32'hDEAD_BEEF);
      exp_st(0, 0, 0, 0);
      step();
      cpu_req = 0;
      exp_ev(K_DMA, 32'h200, 0, 4'hF, 32'h1234_5678);
      step();
      idle();
      exp_ev(K_RV, 32'h0, 0, 4'h0, 32'h1234_5678);
      step();
      step();
      done = 1'b1;
      step();
      step();
   end

endmodule
